// File: rtl/rv_stream_checker.sv
// ---------------------------------------------------------------------------
// rv_stream_checker
//
// Ready/valid sink that applies a selectable backpressure pattern and checks
// every accepted beat against an incrementing sequence starting at `seed`.
// A run is started with a one-cycle `start` pulse and ends after NUM_SEQUENCE
// beats or when the watchdog sees TIMEOUT idle RUN cycles.
//
// Ports:
//   clk            in   clock
//   reset          in   asynchronous active-high reset
//   in_valid       in   sender has data
//   in_data        in   payload [DATA_WIDTH]
//   in_ready       out  checker accepts data (registered-state decode only)
//   start          in   one-cycle pulse, honoured in IDLE or DONE
//   bp_mode        in   0/3 always ready, 1 LFSR random, 2 busy-then-ready
//   seed           in   first expected value and LFSR seed [DATA_WIDTH]
//   rx_count       out  beats accepted this run [COUNT_WIDTH]
//   err_count      out  mismatching beats, saturating [COUNT_WIDTH]
//   first_err_idx  out  index of first mismatching beat [COUNT_WIDTH]
//   done           out  run has ended
//   pass           out  run ended with all beats correct (valid with done)
//   timeout        out  run ended by watchdog
// ---------------------------------------------------------------------------
module rv_stream_checker #(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_SEQUENCE = 16,
    parameter int COUNT_WIDTH  = 16,
    parameter int TIMEOUT      = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   in_ready,
    input  logic                   start,
    input  logic [1:0]             bp_mode,
    input  logic [DATA_WIDTH-1:0]  seed,
    output logic [COUNT_WIDTH-1:0] rx_count,
    output logic [COUNT_WIDTH-1:0] err_count,
    output logic [COUNT_WIDTH-1:0] first_err_idx,
    output logic                   done,
    output logic                   pass,
    output logic                   timeout
);

    localparam int WD_W   = $clog2(TIMEOUT + 1);
    localparam int BUSY_W = $clog2(NUM_SEQUENCE / 2 + 1);

    localparam logic [COUNT_WIDTH-1:0] LAST_IDX  = COUNT_WIDTH'(NUM_SEQUENCE - 1);
    localparam logic [WD_W-1:0]        WD_LIMIT  = WD_W'(TIMEOUT - 1);
    localparam logic [BUSY_W-1:0]      BUSY_INIT = BUSY_W'(NUM_SEQUENCE / 2);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_BUSY_WAIT = 2'd1,
        S_RUN       = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    // 8-bit Fibonacci LFSR, taps 8,6,5,4.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // An all-zero LFSR would lock up, so a zero seed is replaced.
    function automatic logic [7:0] lfsr_seed(input logic [7:0] v);
        return (v == 8'h00) ? 8'hA5 : v;
    endfunction

    state_t                   state_q, state_d;
    logic [DATA_WIDTH-1:0]    expected_q, expected_d;
    logic [7:0]               lfsr_q, lfsr_d;
    logic [1:0]               mode_q, mode_d;
    logic [BUSY_W-1:0]        busy_q, busy_d;
    logic [WD_W-1:0]          wdog_q, wdog_d;
    logic [COUNT_WIDTH-1:0]   rx_count_q, rx_count_d;
    logic [COUNT_WIDTH-1:0]   err_count_q, err_count_d;
    logic [COUNT_WIDTH-1:0]   first_err_q, first_err_d;
    logic                     done_q, done_d;
    logic                     pass_q, pass_d;
    logic                     timeout_q, timeout_d;

    logic [7:0]               seed_lo;
    logic                     hs;
    logic                     mismatch;

    // Low byte of the seed feeds the LFSR; narrow payloads are zero-extended.
    if (DATA_WIDTH >= 8) begin : g_seed_wide
        assign seed_lo = seed[7:0];
    end else begin : g_seed_narrow
        assign seed_lo = {{(8 - DATA_WIDTH){1'b0}}, seed};
    end

    assign in_ready = (state_q == S_RUN) && ((mode_q != 2'd1) || lfsr_q[0]);
    assign hs       = in_valid && in_ready;
    assign mismatch = (in_data != expected_q);

    assign rx_count      = rx_count_q;
    assign err_count     = err_count_q;
    assign first_err_idx = first_err_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign timeout       = timeout_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            expected_q  <= '0;
            lfsr_q      <= '0;
            mode_q      <= '0;
            busy_q      <= '0;
            wdog_q      <= '0;
            rx_count_q  <= '0;
            err_count_q <= '0;
            first_err_q <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            lfsr_q      <= lfsr_d;
            mode_q      <= mode_d;
            busy_q      <= busy_d;
            wdog_q      <= wdog_d;
            rx_count_q  <= rx_count_d;
            err_count_q <= err_count_d;
            first_err_q <= first_err_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        lfsr_d      = lfsr_q;
        mode_d      = mode_q;
        busy_d      = busy_q;
        wdog_d      = wdog_q;
        rx_count_d  = rx_count_q;
        err_count_d = err_count_q;
        first_err_d = first_err_q;
        done_d      = done_q;
        pass_d      = pass_q;
        timeout_d   = timeout_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    rx_count_d  = '0;
                    err_count_d = '0;
                    first_err_d = '0;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    timeout_d   = 1'b0;
                    wdog_d      = '0;
                    expected_d  = seed;
                    lfsr_d      = lfsr_seed(seed_lo);
                    mode_d      = bp_mode;
                    if (bp_mode == 2'd2) begin
                        busy_d  = BUSY_INIT;
                        state_d = S_BUSY_WAIT;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end

            S_BUSY_WAIT: begin
                busy_d = busy_q - 1'b1;
                if (busy_q == BUSY_W'(1)) begin
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                // LFSR free-runs in RUN so the ready pattern is independent
                // of the sender's behaviour.
                lfsr_d = lfsr_next(lfsr_q);
                if (hs) begin
                    wdog_d     = '0;
                    rx_count_d = rx_count_q + 1'b1;
                    expected_d = expected_q + 1'b1;
                    if (mismatch) begin
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + 1'b1;
                        end
                        // err_count saturates and never returns to zero,
                        // so zero reliably means "no error yet".
                        if (err_count_q == '0) begin
                            first_err_d = rx_count_q;
                        end
                    end
                    if (rx_count_q == LAST_IDX) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        pass_d  = (err_count_q == '0) && !mismatch;
                    end
                end else if (wdog_q == WD_LIMIT) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/rv_stream_checker.md
# rv_stream_checker

Synthesizable sink endpoint for the ready/valid stream protocol. It accepts a stream from a sender or buffer under test and applies a selectable backpressure pattern on `in_ready`. It checks every accepted beat against an expected incrementing sequence and reports transfer count, error count, first-error index, timeout and pass/fail. It is the hardware receiver counterpart to the half-buffer stream tests, for use on FPGA and in standalone RTL regressions.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: payload width.
- `NUM_SEQUENCE`, default 16: beats per run; must be ≥ 2 and even.
- `COUNT_WIDTH`, default 16: width of the counters and of `first_err_idx`.
- `TIMEOUT`, default 64: idle cycles in RUN, with no handshake, before the run aborts.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: the sender has data.
- `in_data`, in, DATA_WIDTH: payload.
- `in_ready`, out, 1: the checker accepts data.
- `start`, in, 1: single-cycle pulse that begins a run.
- `bp_mode`, in, 2: backpressure mode, sampled at `start`. 0 = always ready; 1 = LFSR random; 2 = busy-then-ready; 3 = treated as 0.
- `seed`, in, DATA_WIDTH: first expected data value and LFSR seed, sampled at `start`.
- `rx_count`, out, COUNT_WIDTH: beats accepted this run.
- `err_count`, out, COUNT_WIDTH: mismatching beats; saturates at all-ones.
- `first_err_idx`, out, COUNT_WIDTH: index of the first mismatching beat.
- `done`, out, 1: the run has ended.
- `pass`, out, 1: valid while `done` = 1.
- `timeout`, out, 1: the run ended by watchdog.

## Operation
- States: IDLE, BUSY_WAIT, RUN, DONE.
- Reset, applied asynchronously: state IDLE. `in_ready`, `rx_count`, `err_count`, `first_err_idx`, `done`, `pass` and `timeout` are all 0. The expected register, LFSR, busy counter and watchdog are cleared.
- IDLE or DONE with `start` = 1:
  - clear all counters and flags;
  - expected ← `seed`;
  - lfsr ← `seed[7:0]`, or 8'hA5 if that is 0;
  - latch `bp_mode`.
  - Next state is BUSY_WAIT (busy counter ← NUM_SEQUENCE/2) for mode 2, otherwise RUN.
- `start` in BUSY_WAIT or RUN is ignored.
- BUSY_WAIT: `in_ready` = 0. The busy counter decrements each cycle, and at 1 the state moves to RUN.
- RUN:
  - `in_ready` = 1 in modes 0, 2 and 3; `in_ready` = lfsr[0] in mode 1.
  - The LFSR advances every RUN cycle, whether or not a handshake occurs. It is an 8-bit Fibonacci LFSR: lfsr ← {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
- Handshake: `in_valid` && `in_ready` at a rising edge.
  - Compare `in_data` against expected.
  - On a mismatch, `err_count` increments. If this is the first error, `first_err_idx` ← `rx_count` (its pre-increment value).
  - `rx_count` increments and expected ← expected + 1, modulo 2^DATA_WIDTH.
- Run end:
  - A handshake with `rx_count` = NUM_SEQUENCE−1 moves the state to DONE.
  - `pass` = 1 only if no mismatch occurred, including on the final beat.
- Watchdog:
  - Counts RUN cycles since the last handshake, or since entering RUN.
  - Reaching TIMEOUT moves the state to DONE with `timeout` = 1 and `pass` = 0.
  - A handshake in the same cycle takes priority and clears the watchdog.
- DONE: `in_ready` = 0, `done` = 1, and all status outputs hold until `start` or `reset`.
- Reset mid-run aborts immediately; nothing is retained.

## Timing
- `in_ready` is decoded only from registered state, the latched mode and the LFSR. There is no combinational path from `in_valid` or `in_data`.
- `start` at edge N:
  - mode 0/1/3: first possible handshake at edge N+1;
  - mode 2: `in_ready` is low for NUM_SEQUENCE/2 cycles, with the first possible handshake at edge N+1+NUM_SEQUENCE/2.
- Counters and flags update on the edge that performs the handshake and are visible in the following cycle.
- `done` and `pass` become visible in the cycle after the final handshake; `in_ready` drops in that same cycle.
- Back-to-back throughput in modes 0/2/3 is 1 beat per cycle.

## Test plan
- **Mode 0, ideal sender.** `seed`=8'h10, beats 10..1F sent back-to-back → 16 handshakes in 16 consecutive cycles; `done`=1 one cycle after the last beat; `rx_count`=16, `err_count`=0, `pass`=1.
- **Mode 2, busy receiver.** `seed`=8'h00, sender always valid → `in_ready`=0 for 8 cycles after `start`, then 1; 16 beats 00..0F accepted; `pass`=1.
- **Mode 1, random backpressure.** `seed`=8'h5A → `in_ready` matches a bench LFSR model cycle by cycle; the sender holds data while stalled; all 16 beats 5A..69 accepted; `pass`=1.
- **Corruption.** Mode 0, `seed`=8'h10, beat 5 sent as 8'h00 instead of 8'h15 → `err_count`=1, `first_err_idx`=5, `rx_count`=16, `pass`=0.
- **Starved run.** Mode 0, sender stops after 10 beats, TIMEOUT=64 → `done`=1 and `timeout`=1 exactly 64 RUN cycles after the 10th handshake; `rx_count`=10, `pass`=0.
- **Reset mid-run.** Assert `reset` after 7 beats → all outputs 0 immediately, before the next clock edge. A new `start` with `seed`=8'h20 and beats 20..2F → `pass`=1, `rx_count`=16.
